// File: rtl/mix_columns_seq_if.sv
// Valid/ready bundle for the MixColumns engine.
// master drives the state and out_ready; slave returns the mixed state.
interface mix_columns_seq_if;
  logic [127:0] data_in;
  logic         bypass_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output data_in,
    output bypass_in,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  data_out,
    input  out_valid
  );

  modport slave (
    input  data_in,
    input  bypass_in,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output data_out,
    output out_valid
  );
endinterface

// File: rtl/mix_columns_seq.sv
// AES MixColumns engine, COLS_PER_CYCLE columns per clock, valid/ready.
// Ports: clk, rst (sync, active high), bus (slave: state in, mixed out).
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  mix_columns_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] SPAN = 2'(COLS_PER_CYCLE - 1);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
        COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    o0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    o1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    o2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    o3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    return {o0, o1, o2, o3};
  endfunction

  state_t          state_q;
  state_t          state_n;
  // Column c lives at index 3-c so the packed
  // vector matches the data_in byte layout.
  logic [3:0][31:0] cap_q;
  logic [3:0][31:0] res_q;
  logic            byp_q;
  logic [1:0]      cnt_q;
  logic            last;

  assign last = (cnt_q + SPAN) == 2'd3;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_n = BUSY;
      BUSY:    if (last)          state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.data_out  = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
      res_q <= '0;
      byp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            cap_q <= bus.data_in;
            byp_q <= bus.bypass_in;
            cnt_q <= 2'd0;
          end
        end
        BUSY: begin
          // ~(cnt+k) == 3-(cnt+k): storage index of column cnt+k
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            res_q[~(cnt_q + 2'(k))] <= byp_q
              ? cap_q[~(cnt_q + 2'(k))]
              : mix(cap_q[~(cnt_q + 2'(k))]);
          end
          cnt_q <= cnt_q + STEP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns/clock)
// share stimulus and are checked every cycle against a GF(2^8) model.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] din = '0;
  logic         byp = 1'b0;
  logic         iv = 1'b0;
  logic         ordy = 1'b1;
  logic [127:0] lit = '0;
  logic         lit_on = 1'b0;

  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [127:0] dout [3];

  mix_columns_seq_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].data_in   = din;
    assign bus[g].bypass_in = byp;
    assign bus[g].in_valid  = iv;
    assign bus[g].out_ready = ordy;
    assign ir[g]   = bus[g].in_ready;
    assign ov[g]   = bus[g].out_valid;
    assign dout[g] = bus[g].data_out;
    mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d,
                                         input logic b);
    logic [127:0] o;
    logic [7:0]   base [4];
    logic [7:0]   s;
    base = '{8'h02, 8'h03, 8'h01, 8'h01};
    if (b) return d;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        s = '0;
        for (int k = 0; k < 4; k++)
          s = s ^ gmul(base[(k - r + 4) % 4], d[127-32*c-8*k -: 8]);
        o[127-32*c-8*r -: 8] = s;
      end
    return o;
  endfunction

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic ok, input string name, input int i,
                     input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h", name, i, act, req);
    end
  endtask

  logic         pend [3];
  logic [127:0] expv [3];
  logic [127:0] last [3];
  int           acc  [3];
  logic         armed = 1'b0;
  int           lat;
  logic         eov;

  initial begin
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0;
      expv[i] = '0;
      last[i] = '0;
      acc[i]  = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        lat = (4 >> i) + 1;
        eov = pend[i] && (cyc - acc[i] >= lat);
        chk(ir[i] == !pend[i], "in_ready", i,
            128'(ir[i]), 128'(!pend[i]));
        chk(ov[i] == eov, "out_valid", i, 128'(ov[i]), 128'(eov));
        if (eov)
          chk(dout[i] == expv[i], "data_out", i, dout[i], expv[i]);
        if (!pend[i])
          chk(dout[i] == last[i], "data_hold", i, dout[i], last[i]);
      end
    end
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pend[i] = 1'b0;
        last[i] = '0;
      end
      armed = 1'b1;
    end else begin
      if (iv && lit_on && ir[0])
        chk(model(din, byp) == lit, "model_pin", 0, model(din, byp), lit);
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && ov[i] && ordy) begin
          pend[i] = 1'b0;
          last[i] = expv[i];
        end else if (!pend[i] && ir[i] && iv) begin
          pend[i] = 1'b1;
          expv[i] = model(din, byp);
          acc[i]  = cyc;
        end
      end
    end
  end

  task automatic wait_all(input logic want_valid, input logic rnd);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      if (rnd) ordy = 1'($urandom_range(0, 1));
      n++;
      if (n > 300) begin
        $display("FAIL wait_timeout: in_ready=%b out_valid=%b", ir, ov);
        $fatal(1, "bench timeout");
      end
    end while (want_valid ? (ov != 3'b111) : (ir != 3'b111));
  endtask

  task automatic send(input logic [127:0] d, input logic b,
                      input logic [127:0] l, input logic le,
                      input logic rnd);
    wait_all(1'b0, rnd);
    din = d;
    byp = b;
    lit = l;
    lit_on = le;
    iv = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    lit_on = 1'b0;
    if (rnd) ordy = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] INV_IN =
    128'h01010101_c6c6c6c6_d4d4d4d5_00000000;
  localparam logic [127:0] INV_OUT =
    128'h01010101_c6c6c6c6_d5d5d7d6_00000000;
  localparam logic [127:0] BYP_IN =
    128'h00112233_44556677_8899aabb_ccddeeff;

  initial begin
    rst = 1'b1;
    iv = 1'b1;
    din = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    iv = 1'b0;

    send({32'hdb135345, 96'h0}, 1'b0, {32'h8e4da1bc, 96'h0}, 1'b1, 1'b0);
    wait_all(1'b0, 1'b0);
    send({32'hf20a225c, 96'h0}, 1'b0, {32'h9fdc589d, 96'h0}, 1'b1, 1'b0);
    wait_all(1'b0, 1'b0);
    send({32'h2d26314c, 96'h0}, 1'b0, {32'h4d7ebdf8, 96'h0}, 1'b1, 1'b0);
    wait_all(1'b0, 1'b0);
    send(INV_IN, 1'b0, INV_OUT, 1'b1, 1'b0);
    wait_all(1'b0, 1'b0);
    send(BYP_IN, 1'b1, BYP_IN, 1'b1, 1'b0);
    wait_all(1'b0, 1'b0);

    ordy = 1'b0;
    send(rnd128(), 1'b0, '0, 1'b0, 1'b0);
    wait_all(1'b1, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
      iv = 1'b1;
      din = rnd128();
    end
    iv = 1'b0;
    ordy = 1'b1;
    wait_all(1'b0, 1'b0);

    send({32'hdb135345, 96'h0}, 1'b0, {32'h8e4da1bc, 96'h0}, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(INV_IN, 1'b0, INV_OUT, 1'b1, 1'b0);
    wait_all(1'b0, 1'b0);

    for (int n = 0; n < 1000; n++)
      send(rnd128(), 1'($urandom_range(0, 7) == 0), '0, 1'b0, 1'b1);
    ordy = 1'b1;
    wait_all(1'b0, 1'b0);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
